// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU front-end sequencer: FSM state
// encoding (also shown on the LEDs), memory slot addresses and the reserved opcode.
package alu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_LOAD_OP = 3'd3,
        S_EXEC    = 3'd4,
        S_WAIT    = 3'd5,
        S_SHOW    = 3'd6
    } seq_state_t;

    localparam logic [1:0] ADDR_A    = 2'd0;
    localparam logic [1:0] ADDR_B    = 2'd1;
    localparam logic [1:0] ADDR_OP   = 2'd2;
    localparam logic [1:0] ADDR_NONE = 2'd3;

    localparam logic [3:0] OP_NONE = 4'hF;

endpackage

// File: rtl/alu_sequencer_if.sv
// Memory write port and ALU start/done pair driven by the sequencer (master)
// and served by the memory/ALU pair (slave).
interface alu_sequencer_if #(
    parameter int DATA_W = 4
);
    // Handshake: mem_enable qualifies mem_address/mem_write for exactly one cycle
    // and is never back-pressured; alu_start is a one-cycle request, and the ALU
    // answers with alu_done (one or more cycles) while alu_result is valid.
    logic                   mem_enable;
    logic [1:0]             mem_address;
    logic [DATA_W-1:0]      mem_write;
    logic [2:0][DATA_W-1:0] mem_read;
    logic                   alu_start;
    logic                   alu_done;
    logic [DATA_W-1:0]      alu_result;

    modport master (
        output mem_enable, mem_address, mem_write, alu_start,
        input  mem_read, alu_done, alu_result
    );

    modport slave (
        input  mem_enable, mem_address, mem_write, alu_start,
        output mem_read, alu_done, alu_result
    );
endinterface

// File: rtl/enter_conditioner.sv
// Conditions the raw enter button: 2-flop synchronizer, plus a stability
// filter when ALU_SEQ_DEBOUNCE_EN is defined.
module enter_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic enter_clean
);

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int FILTER_CYCLES = DEB_ON ? DEBOUNCE_CYCLES : 0;

    logic sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= enter;
            sync2 <= sync1;
        end
    end

    if (FILTER_CYCLES > 0) begin : g_debounce
        localparam int CW = $clog2(FILTER_CYCLES + 1);
        logic [CW-1:0] cnt;
        logic          level;

        // The level flips only after FILTER_CYCLES consecutive samples disagree with it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign enter_clean = level;
    end else begin : g_bypass
        assign enter_clean = sync2;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller that loads operand A, operand B and opcode into the ALU
// memory, runs the ALU and captures its result. Optional debounce: ALU_SEQ_DEBOUNCE_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int TIMEOUT         = 15,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    input  logic              enter,
    alu_sequencer_if.master   bus,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        state,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic enter_clean, enter_q, step;

    seq_state_t        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    enter_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk         (clk),
        .reset       (reset),
        .enter       (enter),
        .enter_clean (enter_clean)
    );

    assign step = enter_clean & ~enter_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q  <= 1'b0;
            state_q  <= S_IDLE;
            mem_en_q <= 1'b0;
            addr_q   <= ADDR_NONE;
            wdata_q  <= '0;
            start_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            enter_q  <= enter_clean;
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Port values are computed one cycle ahead so every write lands in the cycle after the step.
    always_comb begin
        state_d  = state_q;
        mem_en_d = 1'b0;
        addr_d   = ADDR_NONE;
        wdata_d  = '0;
        start_d  = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (step && state_q != S_EXEC && state_q != S_WAIT) err_d = 1'b0;
        case (state_q)
            S_IDLE:    if (step) state_d = S_LOAD_A;
            S_LOAD_A:  if (step) begin
                mem_en_d = 1'b1; addr_d = ADDR_A; wdata_d = value; state_d = S_LOAD_B;
            end
            S_LOAD_B:  if (step) begin
                mem_en_d = 1'b1; addr_d = ADDR_B; wdata_d = value; state_d = S_LOAD_OP;
            end
            S_LOAD_OP: if (step) begin
                if (value == DATA_W'(OP_NONE)) begin
                    err_d = 1'b1;
                end else begin
                    mem_en_d = 1'b1; addr_d = ADDR_OP; wdata_d = value; state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    result_d = bus.alu_result;
                    state_d  = S_SHOW;
                end else if (cnt_q + 1'b1 == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Address 0 with a live opcode makes the memory clear every slot.
            S_SHOW:    if (step) begin
                mem_en_d = 1'b1; addr_d = ADDR_A; wdata_d = '0; state_d = S_LOAD_A;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    assign bus.mem_enable  = mem_en_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_write   = wdata_q;
    assign bus.alu_start   = start_q;
    assign result          = result_q;
    assign state           = state_q;
    assign busy            = (state_q == S_EXEC) || (state_q == S_WAIT);
    assign err             = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural memory/ALU environment plus a
// step-level model of the operation sequence.
module tb_alu_sequencer;

  localparam int DW  = 4;
  localparam int TO  = 15;
  localparam int DEB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] value = '0;
  logic          enter = 1'b0;
  logic [DW-1:0] result;
  logic [2:0]    state;
  logic          busy, err;

  alu_sequencer_if #(.DATA_W(DW)) bus ();

  alu_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .reset  (reset),
    .value  (value),
    .enter  (enter),
    .bus    (bus),
    .result (result),
    .state  (state),
    .busy   (busy),
    .err    (err)
  );

  // memory environment: writing address 0 while the opcode slot is live clears everything
  logic [3:0] mem [3] = '{4'hF, 4'hF, 4'hF};
  always @(posedge clk) begin
    if (bus.mem_enable) begin
      if (bus.mem_address == 2'd0 && mem[2] != 4'hF) begin
        mem[0] <= 4'hF; mem[1] <= 4'hF; mem[2] <= 4'hF;
      end else if (bus.mem_address != 2'd3) begin
        mem[bus.mem_address] <= bus.mem_write;
      end
    end
  end
  assign bus.mem_read = {mem[2], mem[1], mem[0]};

  initial begin
    bus.alu_done = 1'b0;
    bus.alu_result = '0;
  end

  int checks = 0;
  int errors = 0;

  // reference model of the user-visible behaviour
  int         m_state = 0;
  logic       m_err = 1'b0;
  logic [3:0] m_result = '0;
  logic [3:0] m_mem [3] = '{4'hF, 4'hF, 4'hF};
  logic       m_wr_en = 1'b0;
  logic [1:0] m_wr_addr = 2'd3;
  logic [3:0] m_wr_data = '0;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic void model_write(input int a, input logic [3:0] d);
    m_wr_en = 1'b1; m_wr_addr = 2'(a); m_wr_data = d;
    if (a == 0 && m_mem[2] != 4'hF) begin
      m_mem[0] = 4'hF; m_mem[1] = 4'hF; m_mem[2] = 4'hF;
    end else begin
      m_mem[a] = d;
    end
  endfunction

  function automatic void model_step(input logic [3:0] v);
    m_wr_en = 1'b0; m_wr_addr = 2'd3; m_wr_data = '0;
    case (m_state)
      0: begin m_err = 1'b0; m_state = 1; end
      1: begin m_err = 1'b0; model_write(0, v); m_state = 2; end
      2: begin m_err = 1'b0; model_write(1, v); m_state = 3; end
      3: begin
        m_err = 1'b0;
        if (v == 4'hF) m_err = 1'b1;
        else begin model_write(2, v); m_state = 4; end
      end
      6: begin m_err = 1'b0; model_write(0, 4'h0); m_state = 1; end
      default: ;
    endcase
  endfunction

  // done_cycle 1..TO: ALU answers in that WAIT cycle; 0: it never answers
  function automatic void model_finish(input int done_cycle, input logic [3:0] res);
    if (done_cycle >= 1 && done_cycle <= TO) m_result = res;
    else m_err = 1'b1;
    m_state = 6;
    m_wr_en = 1'b0; m_wr_addr = 2'd3; m_wr_data = '0;
  endfunction

  function automatic logic [8:0] exp_status();
    return {3'(m_state), (m_state == 4 || m_state == 5), m_err, m_result};
  endfunction

  function automatic logic [6:0] exp_port();
    return {m_wr_en, m_wr_addr, m_wr_data};
  endfunction

  function automatic logic [11:0] exp_mem();
    return {m_mem[2], m_mem[1], m_mem[0]};
  endfunction

  // driver tasks: all start and end on a falling edge
  task automatic press(input logic [3:0] v);
    value = v;
    enter = 1'b1;
    repeat (LAT) @(negedge clk);
  endtask

  task automatic release_enter();
    enter = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] a, b;
    reset = 1'b1;
    enter = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({state, busy, err, result, bus.mem_enable, bus.mem_address, bus.mem_write, bus.alu_start}
        !== {3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b11, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_values: got state=%0d err=%b result=%h en=%b addr=%0d", state, err, result, bus.mem_enable, bus.mem_address);
    end
    reset = 1'b0;
    @(negedge clk);
    a = 4'($urandom_range(0, 14));
    b = 4'($urandom_range(0, 14));
    press(4'h0); model_step(4'h0); release_enter();
    press(a); model_step(a); release_enter();
    press(b);
    checks++;
    if ({state, bus.mem_enable, bus.mem_address, bus.mem_write} !== {3'd3, 1'b1, 2'd1, b}) begin
      errors++; $display("FAIL reset_ldb_write: got state=%0d en=%b addr=%0d data=%h expected 3/1/1/%h", state, bus.mem_enable, bus.mem_address, bus.mem_write, b);
    end
    #2 reset = 1'b1;
    enter = 1'b0;
    #1;
    checks++;
    if ({state, busy, err, result, bus.mem_enable, bus.mem_address, bus.mem_write, bus.alu_start}
        !== {3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b11, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_async: got state=%0d en=%b addr=%0d data=%h expected idle", state, bus.mem_enable, bus.mem_address, bus.mem_write);
    end
    @(negedge clk);
    reset = 1'b0;
    m_state = 0; m_err = 1'b0; m_result = '0;
    m_wr_en = 1'b0; m_wr_addr = 2'd3; m_wr_data = '0;
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if ({state, bus.mem_read} !== {3'd0, exp_mem()}) begin
      errors++; $display("FAIL reset_release: got state=%0d mem=%h expected 0 mem=%h", state, bus.mem_read, exp_mem());
    end
  endtask

  task automatic test_held_enter();
    int transitions = 0;
    logic [2:0] prev;
    prev = state;
    value = 4'($urandom);
    enter = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (state !== prev) transitions++;
      prev = state;
    end
    enter = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk);
      if (state !== prev) transitions++;
      prev = state;
    end
    model_step(value);
    checks++;
    if (transitions != 1 || state !== 3'(m_state)) begin
      errors++; $display("FAIL held_enter: got %0d transitions state=%0d expected 1 state=%0d", transitions, state, m_state);
    end
  endtask

  task automatic test_full_op();
    logic [3:0] vals [3] = '{4'd3, 4'd5, 4'd1};
    for (int i = 0; i < 3; i++) begin
      press(vals[i]);
      model_step(vals[i]);
      checks++;
      if ({bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result} !== {exp_port(), exp_status()}) begin
        errors++; $display("FAIL full_write_%0d: got %h expected %h", i, {bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result}, {exp_port(), exp_status()});
      end
      @(negedge clk);
      if (i < 2) begin
        checks++;
        if (bus.mem_read !== exp_mem()) begin
          errors++; $display("FAIL full_mem_%0d: got %h expected %h", i, bus.mem_read, exp_mem());
        end
        release_enter();
      end
    end
    checks++;
    if ({bus.alu_start, state, bus.mem_read} !== {1'b1, 3'd5, 4'd1, 4'd5, 4'd3}) begin
      errors++; $display("FAIL full_start: got start=%b state=%0d mem=%h expected 1/5/153", bus.alu_start, state, bus.mem_read);
    end
    enter = 1'b0;
    repeat (2) @(negedge clk);
    bus.alu_done = 1'b1;
    bus.alu_result = 4'd8;
    @(negedge clk);
    bus.alu_done = 1'b0;
    model_finish(3, 4'd8);
    checks++;
    if ({state, busy, err, result} !== exp_status()) begin
      errors++; $display("FAIL full_result: got %h expected %h", {state, busy, err, result}, exp_status());
    end
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_clear_restart();
    press(4'($urandom));
    model_step(value);
    checks++;
    if ({bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result} !== {exp_port(), exp_status()}) begin
      errors++; $display("FAIL clear_cycle: got %h expected %h", {bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result}, {exp_port(), exp_status()});
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_read, bus.mem_enable, bus.mem_address} !== {12'hFFF, 1'b0, 2'd3}) begin
      errors++; $display("FAIL clear_mem: got mem=%h en=%b addr=%0d expected fff/0/3", bus.mem_read, bus.mem_enable, bus.mem_address);
    end
    release_enter();
    press(4'd7);
    model_step(4'd7);
    @(negedge clk);
    checks++;
    if ({bus.mem_read, state} !== {exp_mem(), 3'(m_state)}) begin
      errors++; $display("FAIL restart_mem: got %h expected %h", {bus.mem_read, state}, {exp_mem(), 3'(m_state)});
    end
    release_enter();
  endtask

  task automatic test_reserved_op();
    press(4'($urandom_range(0, 14)));
    model_step(value);
    release_enter();
    press(4'hF);
    model_step(4'hF);
    checks++;
    if ({bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result} !== {exp_port(), exp_status()}) begin
      errors++; $display("FAIL reserved_op: got %h expected %h", {bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result}, {exp_port(), exp_status()});
    end
    release_enter();
    press(4'd2);
    model_step(4'd2);
    checks++;
    if ({bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result} !== {exp_port(), exp_status()}) begin
      errors++; $display("FAIL reserved_recover: got %h expected %h", {bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result}, {exp_port(), exp_status()});
    end
    @(negedge clk);
    m_state = 5;
    checks++;
    if ({bus.alu_start, bus.mem_read, state} !== {1'b1, exp_mem(), 3'd5}) begin
      errors++; $display("FAIL reserved_start: got %h expected %h", {bus.alu_start, bus.mem_read, state}, {1'b1, exp_mem(), 3'd5});
    end
    enter = 1'b0;
  endtask

  // continues from the first WAIT cycle left by test_reserved_op
  task automatic test_timeout();
    repeat (TO - 1) @(negedge clk);
    checks++;
    if ({state, err} !== {3'd5, 1'b0}) begin
      errors++; $display("FAIL timeout_last_wait: got state=%0d err=%b expected 5/0", state, err);
    end
    @(negedge clk);
    model_finish(0, 4'h0);
    checks++;
    if ({state, busy, err, result} !== exp_status()) begin
      errors++; $display("FAIL timeout_expired: got %h expected %h", {state, busy, err, result}, exp_status());
    end
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic test_random_ops();
    logic [3:0] seq [4];
    logic [11:0] cap;
    int d;
    for (int it = 0; it < 6; it++) begin
      seq[0] = 4'($urandom);
      seq[1] = 4'($urandom);
      seq[2] = 4'($urandom);
      seq[3] = 4'($urandom_range(0, 14));
      d = (it == 0) ? TO : (it == 1) ? 1 : int'($urandom_range(0, TO));
      for (int j = 0; j < 4; j++) begin
        press(seq[j]);
        model_step(seq[j]);
        checks++;
        if ({bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result} !== {exp_port(), exp_status()}) begin
          errors++; $display("FAIL rnd_step_%0d_%0d: got %h expected %h", it, j, {bus.mem_enable, bus.mem_address, bus.mem_write, state, busy, err, result}, {exp_port(), exp_status()});
        end
        @(negedge clk);
        if (j < 3) release_enter();
      end
      checks++;
      if ({bus.alu_start, state, bus.mem_read} !== {1'b1, 3'd5, seq[3], seq[2], seq[1]}) begin
        errors++; $display("FAIL rnd_start_%0d: got %h expected %h", it, {bus.alu_start, state, bus.mem_read}, {1'b1, 3'd5, seq[3], seq[2], seq[1]});
      end
      cap = bus.mem_read;
      enter = 1'b0;
      if (d > 0) begin
        repeat (d - 1) @(negedge clk);
        bus.alu_done = 1'b1;
        bus.alu_result = alu_fn(cap[3:0], cap[7:4], cap[11:8]);
        @(negedge clk);
        bus.alu_done = 1'b0;
      end else begin
        repeat (TO) @(negedge clk);
      end
      model_finish(d, alu_fn(seq[1], seq[2], seq[3]));
      checks++;
      if ({state, busy, err, result} !== exp_status()) begin
        errors++; $display("FAIL rnd_done_%0d (delay %0d): got %h expected %h", it, d, {state, busy, err, result}, exp_status());
      end
      repeat (LAT + 1) @(negedge clk);
    end
  endtask

  task automatic test_ignored_inputs();
    int moved = 0;
    logic [3:0] r;
    for (int j = 0; j < 4; j++) begin
      press((j == 3) ? 4'($urandom_range(0, 14)) : 4'($urandom));
      model_step(value);
      @(negedge clk);
      if (j < 3) release_enter();
    end
    // first WAIT cycle: wiggle enter, which must not move the FSM
    enter = 1'b0;
    for (int k = 1; k < TO; k++) begin
      if (state !== 3'd5) moved++;
      enter = (k == 2 || k == 3 || (k >= 6 && k < 6 + LAT));
      @(negedge clk);
    end
    enter = 1'b0;
    checks++;
    if (moved != 0) begin
      errors++; $display("FAIL ignore_enter_in_wait: got %0d cycles out of WAIT expected 0", moved);
    end
    r = 4'($urandom);
    bus.alu_done = 1'b1;
    bus.alu_result = r;
    @(negedge clk);
    bus.alu_done = 1'b0;
    model_finish(TO, r);
    repeat (LAT + 8) @(negedge clk);
    checks++;
    if ({state, busy, err, result} !== exp_status()) begin
      errors++; $display("FAIL ignore_no_late_step: got %h expected %h", {state, busy, err, result}, exp_status());
    end
    bus.alu_done = 1'b1;
    bus.alu_result = ~r;
    @(negedge clk);
    bus.alu_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, busy, err, result} !== exp_status()) begin
      errors++; $display("FAIL done_outside_wait: got %h expected %h", {state, busy, err, result}, exp_status());
    end
  endtask

  task automatic test_glitch();
    enter = 1'b1;
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    checks++;
    if ({state, bus.mem_read} !== {3'(m_state), exp_mem()}) begin
      errors++; $display("FAIL glitch_filtered: got %h expected %h", {state, bus.mem_read}, {3'(m_state), exp_mem()});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_held_enter();
    test_full_op();
    test_clear_restart();
    test_reserved_op();
    test_timeout();
    test_random_ops();
    test_ignored_inputs();
`ifdef ALU_SEQ_DEBOUNCE_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Front-end controller for the 3-entry operand/opcode memory of the basic ALU. It takes a 4-bit switch value and an `enter` button from the user and walks the memory through operand A (address 0), operand B (address 1) and opcode (address 2). It then starts the ALU, captures the result, and clears the memory before the next operation. It is the only writer of the memory port and sits between the board I/O and the memory/ALU pair.

## Interface
- `DATA_W`, 4: operand, opcode and result width.
- `TIMEOUT`, 15: maximum cycles to wait for `alu_done` after `alu_start`; must be ≥ 1.
- `DEBOUNCE_CYCLES`, 4: stable cycles required on `enter`; used only when debounce is compiled in.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `value`  in  DATA_W  switch value to store.
- `enter`  in  1  raw button level; one accepted rising edge is one user step.
- `mem_enable`  out  1  memory write enable.
- `mem_address`  out  2  memory address; 2'b11 means idle, and the memory ignores it.
- `mem_write`  out  DATA_W  memory write data.
- `mem_read`  in  3×DATA_W  memory contents: [0]=A, [1]=B, [2]=opcode.
- `alu_start`  out  1  one-cycle pulse; the ALU samples `mem_read` on this cycle.
- `alu_done`  in  1  ALU result valid, one cycle or longer.
- `alu_result`  in  DATA_W  ALU result.
- `result`  out  DATA_W  captured result.
- `state`  out  3  current FSM state encoding, for LEDs.
- `busy`  out  1  high in EXEC and WAIT.
- `err`  out  1  sticky error flag, cleared on the next accepted step.

## Operation
- An accepted step is one rising edge of the conditioned `enter`. Edge detection uses a registered copy of the conditioned `enter`.
- States and transitions:
  - IDLE (0): on step, go to LOAD_A.
  - LOAD_A (1): on step, write `value` to address 0, then go to LOAD_B.
  - LOAD_B (2): on step, write `value` to address 1, then go to LOAD_OP.
  - LOAD_OP (3): on step:
    - if `value`≠4'hF, write it to address 2 and go to EXEC;
    - if `value`=4'hF (reserved "no-op" code), do not write, set `err`, and stay in LOAD_OP.
  - EXEC (4): pulse `alu_start` once, then go to WAIT.
  - WAIT (5): on `alu_done`, load `result`←`alu_result` and go to SHOW. If `TIMEOUT` cycles elapse without `alu_done`, set `err`, leave `result` unchanged, and go to SHOW.
  - SHOW (6): on step, issue one clear cycle (`mem_enable`=1, `mem_address`=0, `mem_write`=0), then go to LOAD_A. Because the opcode slot is ≠4'hF, the memory clears all entries to 4'hF instead of writing.
- Memory port outputs:
  - Outside write cycles: `mem_enable`=0, `mem_address`=2'b11, `mem_write`=0.
  - During a write cycle: `mem_enable`=1 for exactly one cycle, and `mem_write` is registered from `value` at step acceptance.
- Steps are ignored in EXEC and WAIT. A step accepted in a state also clears `err` before that state's own checks apply.

## Timing
- Reset values: state IDLE, all memory outputs idle, `alu_start`=0, `result`=0, `busy`=0, `err`=0, timeout counter 0. Reset mid-write forces the idle port values immediately (asynchronously).
- Step to memory write: the write cycle is the cycle after the edge is detected. The new contents appear on `mem_read` one cycle later.
- The opcode write (LOAD_OP exit) is followed by one EXEC cycle, so `alu_start` fires two cycles after the step. This guarantees `mem_read[2]` holds the new opcode when the ALU samples it.
- Timeout counter:
  - starts at 0 on WAIT entry and increments each WAIT cycle;
  - `alu_done` on the same cycle the count reaches `TIMEOUT` wins, so no `err` is set.
- `alu_done` is ignored outside WAIT.
- Held `enter` produces exactly one step; it must be released and pressed again for the next.

## Configuration
- `ALU_SEQ_DEBOUNCE_EN` defined: `enter` passes through a 2-flop synchronizer and then a counter. The conditioned level changes only after `DEBOUNCE_CYCLES` consecutive stable samples, adding 2+`DEBOUNCE_CYCLES` cycles of step latency.
- Undefined: `enter` passes through the 2-flop synchronizer only; `DEBOUNCE_CYCLES` is unused.

## Structure
- Shared package `alu_pkg`:
  - state enum `seq_state_t`;
  - address constants `ADDR_A`=0, `ADDR_B`=1, `ADDR_OP`=2, `ADDR_NONE`=3;
  - reserved opcode `OP_NONE`=4'hF.
- Sub-module `enter_conditioner`: synchronizer plus optional debounce. It outputs the clean `enter` level; the edge detect stays in the top.

## Test plan
- Reset: assert `reset` mid-LOAD_B write → all outputs take their reset values within the same cycle; after release `state`=0.
- Full operation: steps with `value`=3, 5, 1 → memory writes to addresses 0/1/2, `alu_start` 2 cycles after the third step. Then `alu_done` with `alu_result`=8 → `result`=8, `state`=6.
- Reserved opcode: in LOAD_OP, step with `value`=4'hF → no memory write, `err`=1, `state` stays 3. The next step with `value`=2 → `err`=0, opcode written.
- Timeout: no `alu_done` for 15 WAIT cycles → `err`=1, `result` unchanged, SHOW. With `alu_done` on cycle 15 instead → `err`=0.
- Clear and restart: from SHOW, step → one cycle of `mem_address`=0 with `mem_enable`=1, `mem_read` all 4'hF the next cycle, `state`=1. Then step with `value`=7 → `mem_read[0]`=7.
- Held and ignored input: hold `enter` high for 50 cycles in IDLE → exactly one transition. Toggle `enter` during WAIT → no state change. With `ALU_SEQ_DEBOUNCE_EN`, a 2-cycle glitch produces no step.
